sys_dbg_tx: RTL and testbench
=============================

# sys_dbg_tx

Serial debug transmitter for the processor system. It takes a snapshot of one 27-bit LED/debug word together with its 3-bit output-select code and shifts it out LSB-first on a single UART-style line. This lets a host-side receiver read what `SYS_leds` shows without needing 27 physical pins. It sits beside the LED output mux in `system` and is clocked from the same divided system clock.

## Interface
- `DIVISOR`, 16: clock cycles per serial bit; legal range is 1 or more.
- `DATA_W`, 27: width of the debug word; fixed to match the LED bus.
- `clk` input 1: system clock; all logic is on the rising edge.
- `SYS_reset` input 1: reset, asynchronous and active-low.
- `start` input 1: request to capture and send one frame; sampled only in IDLE.
- `sel_in` input 3: output-select code that accompanies the word.
- `data_in` input 27: debug word to send.
- `busy` output 1: high from the cycle after an accepted `start` until the stop bit completes.
- `done` output 1: one-cycle pulse when a frame ends.
- `tx` output 1: serial line; idles high.

## Operation
- Frame order:
  - start bit (0)
  - `sel_in[0..2]`
  - `data_in[0..26]`
  - optional parity bit
  - stop bit (1)
- Frame length is 32 bits, or 33 bits when parity is enabled.
- On an accepted `start`, `{data_in, sel_in}` is latched into a 30-bit shift register. Input changes after that edge have no effect on the frame in flight.
- The FSM has five states, all in `sys_dbg_pkg`:
  - IDLE → START when `start`=1.
  - START → SHIFT after one bit time.
  - SHIFT → PARITY (parity enabled) or STOP (parity disabled) after 30 bit times. A 5-bit bit index counts 0..29.
  - PARITY → STOP after one bit time.
  - STOP → IDLE after one bit time, issuing `done`.
- In SHIFT, `tx` equals shift-register bit 0. The register shifts right at the end of each bit time and zero-fills.
- The baud counter counts 0..DIVISOR-1 and produces a `tick` on the last count. A bit time equals DIVISOR cycles. When DIVISOR=1, `tick` is high every cycle.
- The baud counter is cleared on entry to START, so every frame is phase-aligned to its accepted `start`.
- A `start` pulse while `busy`=1 is ignored and not queued. A `start` in the same cycle `done` is high is also ignored; IDLE is entered on the next cycle.
- `tx` is registered, so no combinational path exists from the inputs to `tx`.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
- Latency:
  - `start` is sampled high at edge N.
  - At edge N+1, `tx` falls to 0 and `busy` rises.
  - The first data bit (`sel_in[0]`) appears at N+1+DIVISOR.
- Frame duration is 32·DIVISOR cycles (33·DIVISOR with parity), measured from the `tx` fall to the end of the stop bit.
- `done` is high for exactly one cycle, on the cycle IDLE is re-entered. `busy` falls on that same edge.
- The earliest back-to-back accept is `start` sampled one cycle after `done`, giving an idle gap of at least 1 cycle of `tx`=1.
- Reset asserted mid-frame: `tx` goes to 1 and `busy` to 0 immediately (asynchronously). No `done` pulse is issued. The next frame needs a fresh `start` after reset is released.

## Configuration
- `SYS_DBG_PARITY_EN`
  - Defined: the PARITY state is compiled in. It sends even parity, i.e. the XOR of all 30 payload bits, so the count of 1s across payload plus parity is even. Frame is 33 bits.
  - Undefined: the PARITY state and parity register are absent. Frame is 32 bits and SHIFT goes directly to STOP.

## Structure
- `sys_dbg_pkg` holds:
  - the state enum (IDLE, START, SHIFT, PARITY, STOP)
  - `PAYLOAD_W`=30
  - `SEL_W`=3
  - `FRAME_BITS`, which is 32 or 33 depending on the macro
- Sub-module `sys_baud_tick`:
  - Parameter: DIVISOR.
  - Inputs: `clk`, `SYS_reset`, synchronous `clr`.
  - Output: `tick`.
  - Counter width is max(1, $clog2(DIVISOR)).
- The top level holds the FSM, shift register, bit index, parity accumulator and output registers.

## Test plan
- Reset with DIVISOR=1, then hold for 10 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- DIVISOR=1, `sel_in`=3'b101, `data_in`=27'h4A5_B3C1, one-cycle `start` → the bench samples 32 bits starting the cycle after `start`: 0, then 1,0,1, then 27'h4A5B3C1 LSB-first, then 1. `done` pulses at cycle 33 and `busy` was high for 32 cycles.
- DIVISOR=4, `data_in`=27'h7FF_FFFF, `sel_in`=3'b111 → every bit is held exactly 4 cycles and the frame totals 128 cycles. With `SYS_DBG_PARITY_EN` the parity bit is 0 (30 ones) and the frame totals 132 cycles.
- DIVISOR=4: `start` again at cycle 20 of a frame, and `data_in` changed mid-frame → the frame carries the originally latched values and exactly one `done` pulse occurs.
- DIVISOR=4: `SYS_reset` asserted low at bit 15, released, then a new `start` with `data_in`=27'h000_0001, `sel_in`=0 → `tx`=1 at once, no `done` for the aborted frame, and the second frame is sent correctly. With parity enabled its parity bit is 1.
- DIVISOR=1: `start` held high continuously → frames are separated by exactly 1 idle-high cycle after each `done`.

Source files
------------

// File: rtl/sys_dbg_pkg.sv
// Purpose: shared types and sizes for the serial debug transmitter.
// Latency: n/a (definitions only).
// Backpressure: n/a. Build option SYS_DBG_PARITY_EN adds the parity bit to FRAME_BITS.
package sys_dbg_pkg;

    localparam int SEL_W     = 3;
    localparam int PAYLOAD_W = 30;          // {data_in, sel_in}
    localparam int IDX_W     = 5;           // bit index 0..29

`ifdef SYS_DBG_PARITY_EN
    localparam int FRAME_BITS = PAYLOAD_W + 3;  // start + payload + parity + stop
`else
    localparam int FRAME_BITS = PAYLOAD_W + 2;  // start + payload + stop
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/sys_dbg_tx_if.sv
// Purpose: request/status bundle between a debug-word source and sys_dbg_tx.
// Latency: n/a (wires only).
// Backpressure: source watches busy; start while busy is dropped, not queued.
interface sys_dbg_tx_if;
    import sys_dbg_pkg::*;

    logic                           start;
    logic [SEL_W-1:0]               sel_in;
    logic [PAYLOAD_W-SEL_W-1:0]     data_in;
    logic                           busy;
    logic                           done;
    logic                           tx;

    modport master (output start, sel_in, data_in, input busy, done, tx);
    modport slave  (input start, sel_in, data_in, output busy, done, tx);
endinterface

// File: rtl/sys_baud_tick.sv
// Purpose: bit-time divider, counts 0..DIVISOR-1 and flags the last count.
// Latency: tick is combinational from the count register; clr takes effect next cycle.
// Backpressure: none, free-running unless cleared.
module sys_baud_tick #(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic SYS_reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // Wrap at the last count; a clear realigns the phase to the caller.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_dbg_tx.sv
// Purpose: snapshot {data_in, sel_in} and send it LSB-first as a UART-style frame on tx.
// Latency: tx drops to the start bit the cycle after start is sampled; 32 (33 with SYS_DBG_PARITY_EN) bit times per frame.
// Backpressure: start is honoured only in IDLE with done low; otherwise it is dropped.
module sys_dbg_tx
    import sys_dbg_pkg::*;
#(
    parameter int DIVISOR = 16,
    parameter int DATA_W  = 27
) (
    input  logic         clk,
    input  logic         SYS_reset,
    sys_dbg_tx_if.slave  dbg
);

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 tick;
`ifdef SYS_DBG_PARITY_EN
    logic                 par_q, par_d;
`endif

    // A start coinciding with the done pulse is dropped so every frame is
    // followed by at least one idle-high cycle.
    assign accept = (state_q == IDLE) && dbg.start && !done_q;

    sys_baud_tick #(.DIVISOR(DIVISOR)) u_baud (
        .clk       (clk),
        .SYS_reset (SYS_reset),
        .clr       (accept),
        .tick      (tick)
    );

    // Next-state, datapath and output decode; tx is derived from the next
    // state so the registered line shows each bit from its first cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef SYS_DBG_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = {dbg.data_in[DATA_W-1:0], dbg.sel_in};
                    idx_d   = '0;
`ifdef SYS_DBG_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[PAYLOAD_W-1:1]};
`ifdef SYS_DBG_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef SYS_DBG_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef SYS_DBG_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        case (state_d)
            START:   tx_d = 1'b0;
            SHIFT:   tx_d = shift_d[0];
`ifdef SYS_DBG_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // All state and outputs registered; reset forces the line idle at once.
    always_ff @(posedge clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SYS_DBG_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SYS_DBG_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign dbg.tx   = tx_q;
    assign dbg.busy = busy_q;
    assign dbg.done = done_q;

endmodule

// File: tb/tb_sys_dbg_tx.sv
// Purpose: scoreboard bench for sys_dbg_tx at DIVISOR=1 and DIVISOR=4.
// Latency: frames expected to start the cycle after an accepted start.
// Backpressure: start while busy or during done must be dropped.
module tb_sys_dbg_tx;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_dbg_tx_if if0 ();
    sys_dbg_tx_if if1 ();

    sys_dbg_tx #(.DIVISOR(1)) u_div1 (.clk(clk), .SYS_reset(rst_n[0]), .dbg(if0.slave));
    sys_dbg_tx #(.DIVISOR(4)) u_div4 (.clk(clk), .SYS_reset(rst_n[1]), .dbg(if1.slave));

    logic [1:0] tx_w, busy_w, done_w;
    assign tx_w   = {if1.tx,   if0.tx};
    assign busy_w = {if1.busy, if0.busy};
    assign done_w = {if1.done, if0.done};

    typedef struct {
        logic [32:0] bits;
        int          nbits;
        int          gap;
        bit          abort;
        int          tag;
    } frame_t;

    frame_t exp_q0[$];
    frame_t exp_q1[$];

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected frame, LSB (start bit) first; par is the hand-computed even parity.
    function automatic frame_t mk(input logic [2:0] s, input logic [26:0] d, input logic par,
                                  input int gap, input bit abort, input int tag);
        frame_t f;
        f.bits        = '1;
        f.bits[0]     = 1'b0;
        f.bits[30:1]  = {d, s};
`ifdef SYS_DBG_PARITY_EN
        f.bits[31]    = par;
        f.nbits       = 33;
`else
        f.nbits       = 32;
`endif
        f.gap   = gap;
        f.abort = abort;
        f.tag   = tag;
        return f;
    endfunction

    // Monitor: on busy rising, pop the expected frame and follow it bit by bit.
    task automatic monitor(input int idx, input int div);
        frame_t      f;
        int          last_done = -1000;
        bit          aborted;
        bit          held;
        logic [32:0] got;
        int          depth;
        forever begin
            @(negedge clk);
            if (rst_n[idx] && busy_w[idx]) begin
                depth = (idx == 0) ? exp_q0.size() : exp_q1.size();
                check($sformatf("frame expected i%0d (queue depth)", idx), 64'(depth > 0), 64'd1);
                if (depth > 0) begin
                    f = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    if (f.gap >= 0)
                        check($sformatf("idle gap i%0d f%0d", idx, f.tag), 64'(cyc - last_done - 1), 64'(f.gap));
                    aborted = 1'b0;
                    held    = 1'b1;
                    got     = '1;
                    for (int b = 0; b < f.nbits && !aborted; b++) begin
                        for (int c = 0; c < div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!rst_n[idx]) begin
                                aborted = 1'b1;
                            end else begin
                                if (c == 0) got[b] = tx_w[idx];
                                else if (tx_w[idx] !== got[b]) held = 1'b0;
                                if (busy_w[idx] !== 1'b1 || done_w[idx] !== 1'b0) held = 1'b0;
                            end
                        end
                    end
                    check($sformatf("aborted i%0d f%0d", idx, f.tag), 64'(aborted), 64'(f.abort));
                    if (aborted) begin
                        check($sformatf("tx in reset i%0d", idx), 64'(tx_w[idx]), 64'd1);
                        check($sformatf("busy in reset i%0d", idx), 64'(busy_w[idx]), 64'd0);
                    end else begin
                        check($sformatf("frame bits i%0d f%0d", idx, f.tag), 64'(got), 64'(f.bits));
                        check($sformatf("bit hold/busy i%0d f%0d", idx, f.tag), 64'(held), 64'd1);
                        @(negedge clk);
                        check($sformatf("done pulse i%0d f%0d", idx, f.tag), 64'(done_w[idx]), 64'd1);
                        check($sformatf("busy after frame i%0d f%0d", idx, f.tag), 64'(busy_w[idx]), 64'd0);
                        check($sformatf("tx after frame i%0d f%0d", idx, f.tag), 64'(tx_w[idx]), 64'd1);
                        last_done = cyc;
                    end
                end
            end
        end
    endtask

    initial monitor(0, 1);
    initial monitor(1, 4);

    always @(negedge clk) begin
        if (done_w[0]) done_cnt0++;
        if (done_w[1]) done_cnt1++;
    end

    task automatic pulse(input int idx, input logic [2:0] s, input logic [26:0] d);
        if (idx == 0) begin if0.sel_in = s; if0.data_in = d; if0.start = 1'b1; end
        else          begin if1.sel_in = s; if1.data_in = d; if1.start = 1'b1; end
        @(negedge clk);
        if (idx == 0) if0.start = 1'b0;
        else          if1.start = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget);
        int n = 0;
        while (!done_w[idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done within %0d cycles i%0d", budget, idx), 64'(done_w[idx]), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 2'b00;
        if0.start   = 1'b0; if0.sel_in = '0; if0.data_in = '0;
        if1.start   = 1'b0; if1.sel_in = '0; if1.data_in = '0;
        repeat (3) @(negedge clk);
        check("reset tx i0",   64'(if0.tx),   64'd1);
        check("reset busy i0", 64'(if0.busy), 64'd0);
        check("reset done i0", 64'(if0.done), 64'd0);
        check("reset tx i1",   64'(if1.tx),   64'd1);
        check("reset busy i1", 64'(if1.busy), 64'd0);
        check("reset done i1", 64'(if1.done), 64'd0);
        rst_n = 2'b11;

        // Idle after reset: line high, no status.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle tx i0",   64'(if0.tx),   64'd1);
            check("idle busy i0", 64'(if0.busy), 64'd0);
            check("idle done i0", 64'(if0.done), 64'd0);
        end

        // Hand parities: 4A5B3C1/101 -> 15 ones; 7FFFFFF/111 -> 30; 1234567/010 -> 13;
        // 0000001/000 -> 1; 5555555/011 -> 16.
        check("hand parity 1", 64'(1'b1), 64'(^{27'h4A5B3C1, 3'b101}));
        check("hand parity 2", 64'(1'b0), 64'(^{27'h7FFFFFF, 3'b111}));
        check("hand parity 3", 64'(1'b1), 64'(^{27'h1234567, 3'b010}));
        check("hand parity 4", 64'(1'b1), 64'(^{27'h0000001, 3'b000}));
        check("hand parity 5", 64'(1'b0), 64'(^{27'h5555555, 3'b011}));

        // DIVISOR=1 basic frame.
        exp_q0.push_back(mk(3'b101, 27'h4A5B3C1, 1'b1, -1, 1'b0, 1));
        pulse(0, 3'b101, 27'h4A5B3C1);
        wait_done(0, 100);

        // DIVISOR=4 all-ones frame.
        exp_q1.push_back(mk(3'b111, 27'h7FFFFFF, 1'b0, -1, 1'b0, 2));
        pulse(1, 3'b111, 27'h7FFFFFF);
        wait_done(1, 200);

        // DIVISOR=4: restart and data change mid-frame are ignored.
        exp_q1.push_back(mk(3'b010, 27'h1234567, 1'b1, -1, 1'b0, 3));
        pulse(1, 3'b010, 27'h1234567);
        repeat (18) @(negedge clk);
        pulse(1, 3'b101, 27'h7654321);
        if1.data_in = 27'h0ABCDEF;
        wait_done(1, 200);
        repeat (10) @(negedge clk);

        // DIVISOR=4: reset during bit 15, then a fresh frame.
        exp_q1.push_back(mk(3'b110, 27'h2AAAAAA, 1'b0, -1, 1'b1, 4));
        pulse(1, 3'b110, 27'h2AAAAAA);
        repeat (61) @(negedge clk);
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check("async reset tx i1",   64'(if1.tx),   64'd1);
        check("async reset busy i1", 64'(if1.busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        exp_q1.push_back(mk(3'b000, 27'h0000001, 1'b1, -1, 1'b0, 5));
        pulse(1, 3'b000, 27'h0000001);
        wait_done(1, 200);

        // DIVISOR=1: start held high across three frames.
        exp_q0.push_back(mk(3'b011, 27'h5555555, 1'b0, -1, 1'b0, 6));
        exp_q0.push_back(mk(3'b011, 27'h5555555, 1'b0,  1, 1'b0, 7));
        exp_q0.push_back(mk(3'b011, 27'h5555555, 1'b0,  1, 1'b0, 8));
        if0.sel_in  = 3'b011;
        if0.data_in = 27'h5555555;
        if0.start   = 1'b1;
        repeat (69) @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        repeat (45) @(negedge clk);

        check("leftover expected frames i0", 64'(exp_q0.size()), 64'd0);
        check("leftover expected frames i1", 64'(exp_q1.size()), 64'd0);
        check("done pulses i0", 64'(done_cnt0), 64'd4);
        check("done pulses i1", 64'(done_cnt1), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
